// File: rtl/audio_arb_pkg.sv
// ============================================================================
// Module      : audio_arb_pkg
// Description : Shared types and constants for the audio FIFO read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  localparam logic PORT_DAC    = 1'b0;
  localparam logic PORT_FFT    = 1'b1;
  localparam int   STALL_CNT_W = 16;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aud_arb_rr_pick.sv
// ============================================================================
// Module      : aud_arb_rr_pick
// Description : Two-way round-robin pick; on a tie the port that did not
//               own the last burst wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aud_arb_rr_pick (
  input  logic [1:0] eligible,
  input  logic       rr_last,
  output logic       pick_vld,
  output logic       pick_id
);

  assign pick_vld = |eligible;
  assign pick_id  = (&eligible) ? ~rr_last : eligible[1];

endmodule

`default_nettype wire

// File: rtl/audio_fifo_rd_arbiter.sv
// ============================================================================
// Module      : audio_fifo_rd_arbiter
// Description : Round-robin burst arbiter sharing one prefetch FIFO read port
//               between a DAC consumer (port 0) and an FFT consumer (port 1).
//               Optional stall statistics: define AUD_ARB_STALL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_fifo_rd_arbiter
  import audio_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_rd_en,
  input  logic              fifo_rd_vld,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              req0,
  input  logic              req1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] m0_data,
  output logic [DATA_W-1:0] m1_data,
  output logic              m0_vld,
  output logic              m1_vld,
  input  logic              m0_rdy,
  input  logic              m1_rdy,
  output logic              m0_last,
  output logic              m1_last,
`ifdef AUD_ARB_STALL_STATS_EN
  input  logic                   stats_clr,
  output logic [STALL_CNT_W-1:0] stall_cnt0,
  output logic [STALL_CNT_W-1:0] stall_cnt1,
`endif
  output logic              busy
);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_last_q, rr_last_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;

  logic [1:0] eligible;
  logic       pick_vld;
  logic       pick_id;
  logic       xfer;
  logic       owner_rdy;
  logic       pop;
  logic       cnt_one;

  assign eligible = {req1 & (len1 != '0), req0 & (len0 != '0)};

  aud_arb_rr_pick u_rr_pick (
    .eligible (eligible),
    .rr_last  (rr_last_q),
    .pick_vld (pick_vld),
    .pick_id  (pick_id)
  );

  assign xfer      = (state_q == ST_XFER);
  assign owner_rdy = (owner_q == PORT_FFT) ? m1_rdy : m0_rdy;
  // No pop in a reset cycle, so an interrupted burst leaves its samples queued.
  assign pop       = xfer & fifo_rd_vld & owner_rdy & ~rst;
  assign cnt_one   = (cnt_q == LEN_W'(1));

  assign fifo_rd_en = pop;
  assign busy       = xfer;
  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign m0_data    = fifo_rd_data;
  assign m1_data    = fifo_rd_data;
  assign m0_vld     = xfer & (owner_q == PORT_DAC) & fifo_rd_vld;
  assign m1_vld     = xfer & (owner_q == PORT_FFT) & fifo_rd_vld;
  assign m0_last    = m0_vld & cnt_one;
  assign m1_last    = m1_vld & cnt_one;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_XFER;
          owner_d = pick_id;
          cnt_d   = pick_id ? len1 : len0;
          gnt0_d  = ~pick_id;
          gnt1_d  = pick_id;
        end
      end
      ST_XFER: begin
        if (pop) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_one) begin
            state_d   = ST_IDLE;
            gnt0_d    = 1'b0;
            gnt1_d    = 1'b0;
            rr_last_d = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= PORT_DAC;
      rr_last_q <= PORT_FFT;
      cnt_q     <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
    end
  end

`ifdef AUD_ARB_STALL_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt0_q, stall_cnt0_d;
  logic [STALL_CNT_W-1:0] stall_cnt1_q, stall_cnt1_d;

  always_comb begin
    stall_cnt0_d = stall_cnt0_q;
    stall_cnt1_d = stall_cnt1_q;
    if (stats_clr) begin
      stall_cnt0_d = '0;
      stall_cnt1_d = '0;
    end else if (xfer && !fifo_rd_vld) begin
      if (owner_q == PORT_DAC) stall_cnt0_d = sat_inc(stall_cnt0_q);
      else                     stall_cnt1_d = sat_inc(stall_cnt1_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt0_q <= '0;
      stall_cnt1_q <= '0;
    end else begin
      stall_cnt0_q <= stall_cnt0_d;
      stall_cnt1_q <= stall_cnt1_d;
    end
  end

  assign stall_cnt0 = stall_cnt0_q;
  assign stall_cnt1 = stall_cnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_fifo_rd_arbiter.sv
// ============================================================================
// Module      : tb_audio_fifo_rd_arbiter
// Description : Directed self-checking bench for audio_fifo_rd_arbiter with a
//               simple prefetch FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_fifo_rd_arbiter;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_rd_en;
  logic              fifo_rd_vld;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              req0, req1;
  logic [LEN_W-1:0]  len0, len1;
  logic              gnt0, gnt1;
  logic [DATA_W-1:0] m0_data, m1_data;
  logic              m0_vld, m1_vld;
  logic              m0_rdy, m1_rdy;
  logic              m0_last, m1_last;
  logic              busy;
`ifdef AUD_ARB_STALL_STATS_EN
  logic              stats_clr;
  logic [15:0]       stall_cnt0, stall_cnt1;
`endif

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:255];
  logic [7:0]  rd_ptr;
  logic [7:0]  wr_ptr;
  logic        fifo_hold;
  logic        tb_flush;
  logic [8:0]  e_g0 = 9'b110000110;
  logic [8:0]  e_g1 = 9'b000110000;

  always #5 clk = ~clk;

  assign fifo_rd_vld  = (rd_ptr != wr_ptr) & ~fifo_hold;
  assign fifo_rd_data = mem[rd_ptr];

  always @(posedge clk) begin
    if (tb_flush)        rd_ptr <= wr_ptr;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;
  end

  audio_fifo_rd_arbiter #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .req0         (req0),
    .req1         (req1),
    .len0         (len0),
    .len1         (len1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .m0_data      (m0_data),
    .m1_data      (m1_data),
    .m0_vld       (m0_vld),
    .m1_vld       (m1_vld),
    .m0_rdy       (m0_rdy),
    .m1_rdy       (m1_rdy),
    .m0_last      (m0_last),
    .m1_last      (m1_last),
`ifdef AUD_ARB_STALL_STATS_EN
    .stats_clr    (stats_clr),
    .stall_cnt0   (stall_cnt0),
    .stall_cnt1   (stall_cnt1),
`endif
    .busy         (busy)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tb_flush = 1'b1; fifo_hold = 1'b0;
    req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
    m0_rdy = 1'b1; m1_rdy = 1'b1;
`ifdef AUD_ARB_STALL_STATS_EN
    stats_clr = 1'b0;
`endif
    nxt();
    rst = 1'b0; tb_flush = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    push(16'h00AA);
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1, busy, fifo_rd_en, m0_vld, m1_vld, m0_last, m1_last} !== 8'h00) begin
      $display("FAIL reset_outputs: got %b want 00000000",
               {gnt0, gnt1, busy, fifo_rd_en, m0_vld, m1_vld, m0_last, m1_last});
      fails++;
    end
`ifdef AUD_ARB_STALL_STATS_EN
    tests++;
    if ({stall_cnt0, stall_cnt1} !== 32'h0) begin
      $display("FAIL reset_stats: got %h/%h want 0/0", stall_cnt0, stall_cnt1);
      fails++;
    end
`endif
    nxt();
  endtask

  task automatic test_single_burst();
    do_reset();
    for (int i = 1; i <= 6; i++) push(16'(i));
    req0 = 1'b1; len0 = 11'd4;
    @(negedge clk);
    tests++;
    if ({gnt0, busy} !== 2'b00) begin
      $display("FAIL single_pre_grant: gnt0/busy=%b want 00", {gnt0, busy});
      fails++;
    end
    nxt();
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({gnt0, m0_vld, fifo_rd_en, m0_last, m1_vld} !== {3'b111, (i == 3), 1'b0}) begin
        $display("FAIL single_ctrl[%0d]: gnt0,vld,rd_en,last,m1_vld=%b want %b", i,
                 {gnt0, m0_vld, fifo_rd_en, m0_last, m1_vld}, {3'b111, (i == 3), 1'b0});
        fails++;
      end
      tests++;
      if (m0_data !== 16'(i + 1)) begin
        $display("FAIL single_data[%0d]: got %h want %h", i, m0_data, 16'(i + 1));
        fails++;
      end
      nxt();
    end
    @(negedge clk);
    tests++;
    if ({gnt0, busy, fifo_rd_en} !== 3'b000) begin
      $display("FAIL single_end: gnt0,busy,rd_en=%b want 000", {gnt0, busy, fifo_rd_en});
      fails++;
    end
    tests++;
    if (8'(wr_ptr - rd_ptr) !== 8'd2) begin
      $display("FAIL single_remaining: got %0d want 2", 8'(wr_ptr - rd_ptr));
      fails++;
    end
    nxt();
  endtask

  task automatic test_tie();
    int k = 0;
    logic b;
    do_reset();
    for (int i = 1; i <= 6; i++) push(16'h0100 + 16'(i));
    req0 = 1'b1; req1 = 1'b1; len0 = 11'd2; len1 = 11'd2;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      b = e_g0[c] | e_g1[c];
      tests++;
      if ({gnt0, gnt1, busy, fifo_rd_en} !== {e_g0[c], e_g1[c], b, b}) begin
        $display("FAIL tie_cycle[%0d]: gnt0,gnt1,busy,rd_en=%b want %b", c,
                 {gnt0, gnt1, busy, fifo_rd_en}, {e_g0[c], e_g1[c], b, b});
        fails++;
      end
      if (b) begin
        tests++;
        if ((e_g1[c] ? {m1_vld, m1_data} : {m0_vld, m0_data}) !== {1'b1, 16'h0101 + 16'(k)}) begin
          $display("FAIL tie_data[%0d]: vld,data=%h want %h", c,
                   (e_g1[c] ? {m1_vld, m1_data} : {m0_vld, m0_data}), {1'b1, 16'h0101 + 16'(k)});
          fails++;
        end
        k++;
      end
      nxt();
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL tie_idle: busy=%b want 0", busy);
      fails++;
    end
    nxt();
  endtask

  task automatic test_stalls();
    do_reset();
    for (int i = 1; i <= 3; i++) push(16'h0200 + 16'(i));
    req1 = 1'b1; len1 = 11'd3; m0_rdy = 1'b0;
    nxt();
    req1 = 1'b0;
    @(negedge clk);
    tests++;
    if ({gnt1, m1_vld, fifo_rd_en, m1_last, m1_data} !== {4'b1110, 16'h0201}) begin
      $display("FAIL stall_first: got %h want %h", {gnt1, m1_vld, fifo_rd_en, m1_last, m1_data},
               {4'b1110, 16'h0201});
      fails++;
    end
    nxt();
    fifo_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({gnt1, busy, m1_vld, fifo_rd_en} !== 4'b1100) begin
        $display("FAIL stall_empty[%0d]: gnt1,busy,vld,rd_en=%b want 1100", i,
                 {gnt1, busy, m1_vld, fifo_rd_en});
        fails++;
      end
      nxt();
    end
    fifo_hold = 1'b0; m1_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({gnt1, m1_vld, fifo_rd_en, m1_last, m1_data} !== {4'b1100, 16'h0202}) begin
        $display("FAIL stall_bp[%0d]: got %h want %h", i,
                 {gnt1, m1_vld, fifo_rd_en, m1_last, m1_data}, {4'b1100, 16'h0202});
        fails++;
      end
      nxt();
    end
    m1_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({gnt1, m1_vld, fifo_rd_en, m1_last, m1_data} !== {3'b111, (i == 1), 16'h0202 + 16'(i)}) begin
        $display("FAIL stall_tail[%0d]: got %h want %h", i,
                 {gnt1, m1_vld, fifo_rd_en, m1_last, m1_data}, {3'b111, (i == 1), 16'h0202 + 16'(i)});
        fails++;
      end
      nxt();
    end
    @(negedge clk);
    tests++;
    if ({gnt1, busy, (rd_ptr == wr_ptr)} !== 3'b001) begin
      $display("FAIL stall_end: gnt1,busy,fifo_empty=%b want 001", {gnt1, busy, (rd_ptr == wr_ptr)});
      fails++;
    end
`ifdef AUD_ARB_STALL_STATS_EN
    tests++;
    if ({stall_cnt0, stall_cnt1} !== {16'd0, 16'd5}) begin
      $display("FAIL stall_stats: got %0d/%0d want 0/5", stall_cnt0, stall_cnt1);
      fails++;
    end
`endif
    nxt();
  endtask

  task automatic test_zero_len();
    do_reset();
    push(16'h0301);
    req0 = 1'b1; len0 = 11'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({gnt0, busy, fifo_rd_en} !== 3'b000) begin
        $display("FAIL zero_len[%0d]: gnt0,busy,rd_en=%b want 000", i, {gnt0, busy, fifo_rd_en});
        fails++;
      end
      nxt();
    end
    req1 = 1'b1; len1 = 11'd1;
    nxt();
    req1 = 1'b0;
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1, m1_vld, m1_last, m1_data} !== {4'b0111, 16'h0301}) begin
      $display("FAIL zero_then_p1: got %h want %h", {gnt0, gnt1, m1_vld, m1_last, m1_data},
               {4'b0111, 16'h0301});
      fails++;
    end
    nxt();
    @(negedge clk);
    tests++;
    if ({gnt0, busy} !== 2'b00) begin
      $display("FAIL zero_after: gnt0,busy=%b want 00", {gnt0, busy});
      fails++;
    end
    req0 = 1'b0;
    nxt();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 8; i++) push(16'h0A00 + 16'(i));
    req0 = 1'b1; len0 = 11'd8;
    nxt();
    req0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({fifo_rd_en, m0_data} !== {1'b1, 16'h0A00 + 16'(i)}) begin
        $display("FAIL rstmid_pop[%0d]: got %h want %h", i, {fifo_rd_en, m0_data},
                 {1'b1, 16'h0A00 + 16'(i)});
        fails++;
      end
      nxt();
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (fifo_rd_en !== 1'b0) begin
      $display("FAIL rstmid_rst_cycle: rd_en=%b want 0", fifo_rd_en);
      fails++;
    end
    nxt();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({gnt0, busy, fifo_rd_en, 8'(wr_ptr - rd_ptr)} !== {3'b000, 8'd6}) begin
      $display("FAIL rstmid_after: gnt0,busy,rd_en,left=%h want %h",
               {gnt0, busy, fifo_rd_en, 8'(wr_ptr - rd_ptr)}, {3'b000, 8'd6});
      fails++;
    end
    req0 = 1'b1; len0 = 11'd1;
    nxt();
    req0 = 1'b0;
    @(negedge clk);
    tests++;
    if ({gnt0, m0_vld, m0_last, fifo_rd_en, m0_data} !== {4'b1111, 16'h0A02}) begin
      $display("FAIL rstmid_resume: got %h want %h", {gnt0, m0_vld, m0_last, fifo_rd_en, m0_data},
               {4'b1111, 16'h0A02});
      fails++;
    end
    nxt();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL rstmid_done: busy=%b want 0", busy);
      fails++;
    end
    nxt();
  endtask

`ifdef AUD_ARB_STALL_STATS_EN
  task automatic test_saturation();
    do_reset();
    req0 = 1'b1; len0 = 11'd1;
    nxt();
    req0 = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if ({gnt0, stall_cnt0} !== {1'b1, 16'hFFFF}) begin
      $display("FAIL sat_value: gnt0,cnt=%h want %h", {gnt0, stall_cnt0}, {1'b1, 16'hFFFF});
      fails++;
    end
    stats_clr = 1'b1;
    nxt();
    stats_clr = 1'b0;
    @(negedge clk);
    tests++;
    if (stall_cnt0 !== 16'h0000) begin
      $display("FAIL sat_clear: got %h want 0000", stall_cnt0);
      fails++;
    end
    push(16'h0B00);
    nxt();
    @(negedge clk);
    tests++;
    if ({busy, gnt0} !== 2'b00) begin
      $display("FAIL sat_finish: busy,gnt0=%b want 00", {busy, gnt0});
      fails++;
    end
    nxt();
  endtask
`endif

  initial begin
    wr_ptr = 8'd0;
    test_reset();
    test_single_burst();
    test_tie();
    test_stalls();
    test_zero_len();
    test_reset_mid_burst();
`ifdef AUD_ARB_STALL_STATS_EN
    test_saturation();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
